roll_arbiter: RTL and testbench
===============================

ROLL_ARBITER -- requirements
Module: roll_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter START_TO, default 16, giving the maximum number of cycles to wait for the generator busy signal after a start pulse.
REQ-003 The block SHALL have parameter ROLL_TO, default 2^26, giving the number of cycles of roll allowed before a forced stop.
REQ-004 i_clk  input  1  clock; all state changes on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_req  input  N_REQ  one-cycle request pulses, one bit per requester (debounced keys).
REQ-007 o_gnt  output  N_REQ  one-hot grant, held from the start pulse until capture or abort.
REQ-008 o_rng_start  output  1  one-cycle start/stop pulse to the random generator.
REQ-009 i_rng_busy  input  1  generator rolling indicator.
REQ-010 i_rng_value  input  4  generator current output.
REQ-011 o_result / o_result_owner / o_result_valid  output  4 / clog2(N_REQ) / 1  captured value, its owner index, one-cycle valid pulse.
REQ-012 o_err  output  1  one-cycle pulse on start timeout.
REQ-013 o_busy  output  1  high whenever state is not IDLE.
REQ-014 i_rd_sel / o_rd_value  input clog2(N_REQ) / output 4  combinational read of the last result stored for the selected requester.

Function
REQ-015 Each requester SHALL have a sticky pending bit, set on the edge sampling i_req[i]=1 and cleared on the edge its grant is issued; set-and-clear in the same cycle SHALL leave the bit set.
REQ-016 A request from the current owner during its roll SHALL be queued as pending, not merged into the current roll.
REQ-017 The state machine SHALL have the states IDLE, START, WAIT_BUSY, ROLL and CAPTURE; all outputs SHALL be registered.
REQ-018 In IDLE with any pending bit set, the block SHALL grant the first pending index at or after rr_ptr (wrapping modulo N_REQ) and enter START.
REQ-019 o_gnt SHALL assert, and o_rng_start SHALL pulse for exactly one cycle, in START; o_rng_start SHALL rise 2 edges after the edge sampling i_req from IDLE with no other pending bits.
REQ-020 WAIT_BUSY SHALL count cycles; on i_rng_busy=1 it SHALL go to ROLL with the counter cleared.
REQ-021 If the WAIT_BUSY count reaches START_TO, the block SHALL pulse o_err, clear o_gnt, set rr_ptr=owner+1 mod N_REQ and return to IDLE.
REQ-022 In ROLL, i_rng_busy=0 SHALL move the block to CAPTURE.
REQ-023 If the ROLL count reaches ROLL_TO, the block SHALL issue exactly one o_rng_start stop pulse and then wait in ROLL, without a timeout, for i_rng_busy=0.
REQ-024 In CAPTURE the block SHALL:
- latch i_rng_value into o_result and into hist[owner];
- drive o_result_owner and pulse o_result_valid for one cycle;
- clear o_gnt and set rr_ptr=owner+1 mod N_REQ;
- return to IDLE.
REQ-025 Simultaneous requests SHALL be served in round-robin order, one roll each, with no requester starved.
REQ-026 The 27-bit timeout counter SHALL saturate and never wrap.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately clear o_gnt, o_rng_start, o_result, o_result_owner, o_result_valid, o_err, o_busy, pending bits, rr_ptr, the counter and hist, and SHALL force IDLE.
REQ-028 Reset during ROLL SHALL NOT emit a stop pulse; after release the block SHALL be IDLE with no pending requests.

Verification
REQ-029 Single request: i_req=0001 pulse, generator busy 3 cycles after start then low with value 4'hA -> start pulse 2 edges after request, o_result=A, owner=0, valid for 1 cycle, o_rd_value(sel 0)=A.
REQ-030 Simultaneous i_req=1011 from IDLE with rr_ptr=0 -> grants in order 0001, 0010, 1000, one roll each.
REQ-031 Busy never rises with START_TO=16 -> o_err pulse 16 cycles after WAIT_BUSY entry, o_gnt=0, rr_ptr advanced, no result.
REQ-032 Busy stuck high with ROLL_TO=100 -> single stop pulse at count 100; busy low 5 cycles later -> capture occurs.
REQ-033 Owner re-requests mid-roll -> pending re-set; after capture the same owner is regranted only if no other requester is pending.
REQ-034 Reset asserted mid-ROLL -> all outputs 0 asynchronously, no o_rng_start pulse, IDLE after release.

Source files
------------

// File: rtl/roll_arbiter_if.sv
// Bus between the roll arbiter and its requesters/random generator/readback logic.
// The arbiter connects through the slave modport; the requester side uses master.
interface roll_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] i_req;
    logic [N_REQ-1:0] o_gnt;
    logic             o_rng_start;
    logic             i_rng_busy;
    logic [3:0]       i_rng_value;
    logic [3:0]       o_result;
    logic [IW-1:0]    o_result_owner;
    logic             o_result_valid;
    logic             o_err;
    logic             o_busy;
    logic [IW-1:0]    i_rd_sel;
    logic [3:0]       o_rd_value;

    modport slave (
        input  i_req, i_rng_busy, i_rng_value, i_rd_sel,
        output o_gnt, o_rng_start, o_result, o_result_owner, o_result_valid,
               o_err, o_busy, o_rd_value
    );

    modport master (
        output i_req, i_rng_busy, i_rng_value, i_rd_sel,
        input  o_gnt, o_rng_start, o_result, o_result_owner, o_result_valid,
               o_err, o_busy, o_rd_value
    );
endinterface

// File: rtl/roll_arbiter.sv
// Round-robin arbiter sharing one random generator among N_REQ requesters:
// grant, start the roll, wait for the generator to stop, capture its value per owner.
module roll_arbiter #(
    parameter int N_REQ    = 4,
    parameter int START_TO = 16,
    parameter int ROLL_TO  = 2**26
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    roll_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = 27;

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, ROLL, CAPTURE} state_t;

    state_t                 state_q, state_d;
    logic [N_REQ-1:0]       pend_q, pend_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic [3:0]             res_q, res_d;
    logic [IW-1:0]          res_own_q, res_own_d;
    logic [N_REQ-1:0][3:0]  hist_q, hist_d;

    logic [IW-1:0]          pick;
    logic [N_REQ-1:0]       pick_oh;
    logic [IW-1:0]          rr_nxt;
    logic [N_REQ-1:0]       clr;

    // Scan from the highest offset down so the first pending at/after rr_q wins.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % N_REQ;
            if (pend_q[IW'(idx)]) pick = IW'(idx);
        end
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    assign rr_nxt = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        clr       = '0;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        err_d     = 1'b0;
        valid_d   = 1'b0;
        res_d     = res_q;
        res_own_d = res_own_q;
        hist_d    = hist_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    owner_d = pick;
                    gnt_d   = pick_oh;
                    clr     = pick_oh;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.i_rng_busy) begin
                    cnt_d   = '0;
                    state_d = ROLL;
                end else if (cnt_q == CW'(START_TO - 1)) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    rr_d    = rr_nxt;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ROLL: begin
                if (!bus.i_rng_busy) begin
                    state_d = CAPTURE;
                end else begin
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    // Counter is monotonic and saturates above ROLL_TO-1: one stop pulse only.
                    if (cnt_q == CW'(ROLL_TO - 1)) start_d = 1'b1;
                end
            end
            CAPTURE: begin
                res_d          = bus.i_rng_value;
                hist_d[owner_q] = bus.i_rng_value;
                res_own_d      = owner_q;
                valid_d        = 1'b1;
                gnt_d          = '0;
                rr_d           = rr_nxt;
                cnt_d          = '0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new request on the grant edge wins over the clear.
        pend_d = (pend_q & ~clr) | bus.i_req;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            res_q     <= '0;
            res_own_q <= '0;
            hist_q    <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            res_q     <= res_d;
            res_own_q <= res_own_d;
            hist_q    <= hist_d;
        end
    end

    assign bus.o_gnt          = gnt_q;
    assign bus.o_rng_start    = start_q;
    assign bus.o_result       = res_q;
    assign bus.o_result_owner = res_own_q;
    assign bus.o_result_valid = valid_q;
    assign bus.o_err          = err_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_rd_value     = hist_q[bus.i_rd_sel];
endmodule

// File: tb/tb_roll_arbiter.sv
// Directed bench for roll_arbiter: latency, round-robin order, both timeouts,
// re-request queueing and asynchronous reset during a roll.
module tb_roll_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    roll_arbiter_if #(.N_REQ(4)) bus ();

    roll_arbiter #(.N_REQ(4), .START_TO(16), .ROLL_TO(100)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.i_req = '0; bus.i_rng_busy = 1'b0; bus.i_rng_value = '0; bus.i_rd_sel = '0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    // Plays the generator for one grant; reports what it saw, no checking here.
    task automatic run_roll(input logic [3:0] val, input int roll_cyc, input logic [3:0] mid_req,
                            output logic [3:0] gnt_seen, output logic [1:0] own_seen,
                            output logic [3:0] res_seen, output bit ok);
        ok = 0; gnt_seen = '0; own_seen = '0; res_seen = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_rng_start) break;
            tick;
        end
        if (!bus.o_rng_start) return;
        gnt_seen = bus.o_gnt;
        bus.i_rng_busy = 1'b1;
        tick;
        for (int i = 0; i < roll_cyc; i++) begin
            if (i == 0) bus.i_req = mid_req;
            tick;
            bus.i_req = '0;
        end
        bus.i_rng_busy = 1'b0; bus.i_rng_value = val;
        tick;
        tick;
        if (bus.o_result_valid) begin
            ok = 1; own_seen = bus.o_result_owner; res_seen = bus.o_result;
        end
    endtask

    task automatic test_reset;
        bus.i_req = '0; bus.i_rng_busy = 1'b0; bus.i_rng_value = '0; bus.i_rd_sel = '0;
        rst_n = 1'b0;
        tick; tick;
        checks++; if ({bus.o_gnt, bus.o_rng_start, bus.o_result_valid, bus.o_err, bus.o_busy} !== 8'h00) begin
            errs++; $display("FAIL reset_ctrl got=%0h exp=0", {bus.o_gnt, bus.o_rng_start, bus.o_result_valid, bus.o_err, bus.o_busy}); end
        checks++; if ({bus.o_result, bus.o_result_owner, bus.o_rd_value} !== 10'h000) begin
            errs++; $display("FAIL reset_data got=%0h exp=0", {bus.o_result, bus.o_result_owner, bus.o_rd_value}); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        do_reset;
        bus.i_req = 4'b0001; tick; bus.i_req = '0;
        checks++; if ({bus.o_gnt, bus.o_rng_start} !== 5'b0) begin
            errs++; $display("FAIL single_e0 got=%0h exp=0", {bus.o_gnt, bus.o_rng_start}); end
        tick;
        checks++; if ({bus.o_gnt, bus.o_rng_start, bus.o_busy} !== 6'b0001_0_1) begin
            errs++; $display("FAIL single_grant got=%0b exp=000101", {bus.o_gnt, bus.o_rng_start, bus.o_busy}); end
        tick;
        checks++; if (bus.o_rng_start !== 1'b1) begin
            errs++; $display("FAIL single_start_lat got=%0b exp=1", bus.o_rng_start); end
        tick;
        checks++; if (bus.o_rng_start !== 1'b0) begin
            errs++; $display("FAIL single_start_width got=%0b exp=0", bus.o_rng_start); end
        tick;
        bus.i_rng_busy = 1'b1;
        tick; tick; tick; tick;
        bus.i_rng_busy = 1'b0; bus.i_rng_value = 4'hA;
        tick;
        checks++; if (bus.o_result_valid !== 1'b0) begin
            errs++; $display("FAIL single_valid_early got=%0b exp=0", bus.o_result_valid); end
        tick;
        bus.i_rd_sel = 2'd0;
        #1;
        checks++; if ({bus.o_result_valid, bus.o_result, bus.o_result_owner, bus.o_gnt} !== {1'b1, 4'hA, 2'd0, 4'b0}) begin
            errs++; $display("FAIL single_capture got=%0h exp=%0h", {bus.o_result_valid, bus.o_result, bus.o_result_owner, bus.o_gnt}, {1'b1, 4'hA, 2'd0, 4'b0}); end
        checks++; if (bus.o_rd_value !== 4'hA) begin
            errs++; $display("FAIL single_rd got=%0h exp=a", bus.o_rd_value); end
        tick;
        checks++; if ({bus.o_result_valid, bus.o_busy} !== 2'b00) begin
            errs++; $display("FAIL single_valid_width got=%0b exp=00", {bus.o_result_valid, bus.o_busy}); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [3] = '{4'b0001, 4'b0010, 4'b1000};
        logic [1:0] exp_o [3] = '{2'd0, 2'd1, 2'd3};
        logic [3:0] g, r; logic [1:0] o; bit ok;
        do_reset;
        bus.i_req = 4'b1011; tick; bus.i_req = '0;
        for (int n = 0; n < 3; n++) begin
            run_roll(4'(n + 1), 2, 4'b0, g, o, r, ok);
            checks++; if (!ok || g !== exp_g[n] || o !== exp_o[n] || r !== 4'(n + 1)) begin
                errs++; $display("FAIL rr_grant%0d got ok=%0d g=%0b o=%0d r=%0h exp g=%0b o=%0d r=%0h", n, ok, g, o, r, exp_g[n], exp_o[n], n + 1); end
        end
        tick; tick;
        checks++; if (bus.o_busy !== 1'b0) begin
            errs++; $display("FAIL rr_idle got=%0b exp=0", bus.o_busy); end
        bus.i_rd_sel = 2'd3; #1;
        checks++; if (bus.o_rd_value !== 4'h3) begin
            errs++; $display("FAIL rr_hist3 got=%0h exp=3", bus.o_rd_value); end
    endtask

    task automatic test_start_timeout;
        int lat; bit vseen; logic [3:0] g, r; logic [1:0] o; bit ok;
        lat = -1; vseen = 0;
        do_reset;
        bus.i_req = 4'b0010; tick; bus.i_req = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_rng_start) break;
            tick;
        end
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (bus.o_result_valid) vseen = 1;
            if (bus.o_err) begin lat = k; break; end
        end
        checks++; if (lat != 16) begin
            errs++; $display("FAIL start_to_lat got=%0d exp=16", lat); end
        checks++; if ({bus.o_gnt, bus.o_busy, vseen} !== 6'b0) begin
            errs++; $display("FAIL start_to_state got=%0b exp=0", {bus.o_gnt, bus.o_busy, vseen}); end
        tick;
        checks++; if (bus.o_err !== 1'b0) begin
            errs++; $display("FAIL start_to_err_width got=%0b exp=0", bus.o_err); end
        // rr_ptr now 2: requester 2 must beat requester 1.
        bus.i_req = 4'b0110; tick; bus.i_req = '0;
        run_roll(4'h7, 2, 4'b0, g, o, r, ok);
        checks++; if (!ok || g !== 4'b0100 || o !== 2'd2) begin
            errs++; $display("FAIL start_to_rr got ok=%0d g=%0b o=%0d exp g=0100 o=2", ok, g, o); end
        run_roll(4'h9, 2, 4'b0, g, o, r, ok);
        checks++; if (!ok || g !== 4'b0010 || r !== 4'h9) begin
            errs++; $display("FAIL start_to_rr2 got ok=%0d g=%0b r=%0h exp g=0010 r=9", ok, g, r); end
    endtask

    task automatic test_roll_timeout;
        int lat, extra;
        lat = -1; extra = 0;
        do_reset;
        bus.i_req = 4'b0001; tick; bus.i_req = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_rng_start) break;
            tick;
        end
        bus.i_rng_busy = 1'b1;
        tick;
        for (int k = 1; k <= 200; k++) begin
            tick;
            if (bus.o_rng_start) begin lat = k; break; end
        end
        checks++; if (lat != 100) begin
            errs++; $display("FAIL roll_to_lat got=%0d exp=100", lat); end
        for (int i = 0; i < 5; i++) begin
            tick;
            if (bus.o_rng_start) extra++;
        end
        checks++; if (extra != 0 || bus.o_busy !== 1'b1) begin
            errs++; $display("FAIL roll_to_single got extra=%0d busy=%0b exp 0/1", extra, bus.o_busy); end
        bus.i_rng_busy = 1'b0; bus.i_rng_value = 4'h5;
        tick; tick;
        checks++; if ({bus.o_result_valid, bus.o_result} !== 5'h15) begin
            errs++; $display("FAIL roll_to_capture got=%0h exp=15", {bus.o_result_valid, bus.o_result}); end
    endtask

    task automatic test_rerequest;
        logic [3:0] g, r; logic [1:0] o; bit ok;
        do_reset;
        bus.i_req = 4'b0001; tick; bus.i_req = '0;
        run_roll(4'h3, 3, 4'b0001, g, o, r, ok);
        checks++; if (!ok || g !== 4'b0001 || r !== 4'h3) begin
            errs++; $display("FAIL rereq_first got ok=%0d g=%0b r=%0h exp g=0001 r=3", ok, g, r); end
        run_roll(4'h4, 3, 4'b0101, g, o, r, ok);
        checks++; if (!ok || g !== 4'b0001 || r !== 4'h4) begin
            errs++; $display("FAIL rereq_alone got ok=%0d g=%0b r=%0h exp g=0001 r=4", ok, g, r); end
        run_roll(4'h6, 2, 4'b0, g, o, r, ok);
        checks++; if (!ok || g !== 4'b0100 || o !== 2'd2) begin
            errs++; $display("FAIL rereq_other got ok=%0d g=%0b o=%0d exp g=0100 o=2", ok, g, o); end
        run_roll(4'h8, 2, 4'b0, g, o, r, ok);
        checks++; if (!ok || g !== 4'b0001 || r !== 4'h8) begin
            errs++; $display("FAIL rereq_back got ok=%0d g=%0b r=%0h exp g=0001 r=8", ok, g, r); end
    endtask

    // Entered with hist[0]=8 left from the previous scenario.
    task automatic test_reset_mid_roll;
        int pulses;
        pulses = 0;
        bus.i_rd_sel = 2'd0;
        bus.i_req = 4'b0001; tick; bus.i_req = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.o_rng_start) break;
            tick;
        end
        bus.i_rng_busy = 1'b1;
        tick; tick; tick;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.o_gnt, bus.o_rng_start, bus.o_result_valid, bus.o_err, bus.o_busy} !== 8'h00) begin
            errs++; $display("FAIL rst_roll_ctrl got=%0h exp=0", {bus.o_gnt, bus.o_rng_start, bus.o_result_valid, bus.o_err, bus.o_busy}); end
        checks++; if ({bus.o_result, bus.o_result_owner, bus.o_rd_value} !== 10'h000) begin
            errs++; $display("FAIL rst_roll_data got=%0h exp=0", {bus.o_result, bus.o_result_owner, bus.o_rd_value}); end
        for (int i = 0; i < 3; i++) begin
            tick;
            if (bus.o_rng_start) pulses++;
        end
        rst_n = 1'b1;
        bus.i_rng_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (bus.o_rng_start) pulses++;
        end
        checks++; if (pulses != 0 || {bus.o_busy, bus.o_gnt} !== 5'b0) begin
            errs++; $display("FAIL rst_roll_after got pulses=%0d busy/gnt=%0b exp 0", pulses, {bus.o_busy, bus.o_gnt}); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_start_timeout;
        test_roll_timeout;
        test_rerequest;
        test_reset_mid_roll;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
